// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches one word at a time over a req/ack imem port,
// predicts B-type branches with a 2-bit BHT and JAL as taken, and feeds ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_branch_pc,
    input  logic        i_bp_upd_valid,
    input  logic [31:0] i_bp_upd_pc,
    input  logic        i_bp_upd_taken,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_prediction
);
    localparam int BHT_N = 1 << BHT_IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } fpkt_t;

    localparam fpkt_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pred: 1'b0};

    state_t               r_state, w_next_state;
    logic [31:0]          r_pc;
    fpkt_t                r_out, r_buf;
    logic                 r_buf_vld;
    logic [1:0]           r_bht [BHT_N];

    logic [31:0]          w_b_imm, w_j_imm, w_next_pc;
    logic                 w_pred, w_outstanding, w_take;
    logic [BHT_IDX_W-1:0] w_lkp_idx, w_upd_idx;
    fpkt_t                w_fetched;
    logic                 w_unused;

    assign w_lkp_idx = r_pc[BHT_IDX_W+1:2];
    assign w_upd_idx = i_bp_upd_pc[BHT_IDX_W+1:2];
    assign w_unused  = &{1'b0, i_bp_upd_pc[31:BHT_IDX_W+2], i_bp_upd_pc[1:0]};

    assign w_b_imm = {{20{i_imem_data[31]}}, i_imem_data[7], i_imem_data[30:25],
                      i_imem_data[11:8], 1'b0};
    assign w_j_imm = {{12{i_imem_data[31]}}, i_imem_data[19:12], i_imem_data[20],
                      i_imem_data[30:21], 1'b0};

    // Prediction looks at the word arriving on the bus, against the PC it was fetched from.
    always_comb begin
        w_pred    = 1'b0;
        w_next_pc = r_pc + 32'd4;
        case (i_imem_data[6:0])
            7'b1100011: begin
                w_pred = r_bht[w_lkp_idx][1];
                if (w_pred) w_next_pc = r_pc + w_b_imm;
            end
            7'b1101111: begin
                w_pred    = 1'b1;
                w_next_pc = r_pc + w_j_imm;
            end
            default: ;
        endcase
    end

    assign w_fetched = '{instr: i_imem_data, pc: r_pc, pred: w_pred};
    assign w_take    = o_imem_req && i_imem_ack && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_REQ;
            S_REQ:   ;
            S_DRAIN: if (i_imem_ack) w_next_state = S_REQ;
            default: w_next_state = S_IDLE;
        endcase
        // A request still in flight at flush time must have its response swallowed.
        if (i_flush) w_next_state = (w_outstanding && !i_imem_ack) ? S_DRAIN : S_REQ;
    end

    // The request is held while a skid entry is pending so nothing can overrun it.
    always_comb begin
        o_imem_req    = (r_state == S_REQ) && !r_buf_vld;
        w_outstanding = o_imem_req || (r_state == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_out     <= BUBBLE;
            r_buf     <= BUBBLE;
            r_buf_vld <= 1'b0;
        end else if (i_flush) begin
            r_pc      <= i_branch_pc;
            r_out     <= BUBBLE;
            r_buf_vld <= 1'b0;
        end else begin
            if (w_take) r_pc <= w_next_pc;
            if (!i_stall) begin
                if (r_buf_vld) begin
                    r_out     <= r_buf;
                    r_buf_vld <= 1'b0;
                end else if (w_take) begin
                    r_out <= w_fetched;
                end else begin
                    r_out.instr <= NOP_INSTR;
                    r_out.pred  <= 1'b0;
                end
            end else if (w_take) begin
                r_buf     <= w_fetched;
                r_buf_vld <= 1'b1;
            end
        end
    end

    // Written at the edge, so a lookup in the same cycle still reads the old counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
        end else if (i_bp_upd_valid) begin
            if (i_bp_upd_taken && r_bht[w_upd_idx] != 2'b11)
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
            else if (!i_bp_upd_taken && r_bht[w_upd_idx] != 2'b00)
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
        end
    end

    assign o_imem_addr  = r_pc;
    assign o_instr      = r_out.instr;
    assign o_pc         = r_out.pc;
    assign o_prediction = r_out.pred;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model plus an in-order
// scoreboard of fetched words, directed vectors and a random run.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_imem_req, o_prediction;
    logic [31:0] o_imem_addr, o_instr, o_pc;
    logic        i_imem_ack, i_stall, i_flush, i_bp_upd_valid, i_bp_upd_taken;
    logic [31:0] i_imem_data, i_branch_pc, i_bp_upd_pc;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .i_stall(i_stall), .i_flush(i_flush), .i_branch_pc(i_branch_pc),
        .i_bp_upd_valid(i_bp_upd_valid), .i_bp_upd_pc(i_bp_upd_pc),
        .i_bp_upd_taken(i_bp_upd_taken),
        .o_instr(o_instr), .o_pc(o_pc), .o_prediction(o_prediction)
    );

    typedef struct { logic [31:0] instr; logic [31:0] pc; logic pred; } ent_t;
    typedef struct {
        logic [31:0] pc; logic [31:0] instr; int kind; int off; int ntaken;
        logic [31:0] exp_next; logic exp_pred;
    } vec_t;

    int checks = 0, failures = 0;

    // Program image: word, class (0 other, 1 cond branch, 2 JAL) and byte offset.
    logic [31:0] prog [256];
    int          kind [256];
    int          off  [256];
    int          bht_m [64];
    ent_t        q[$];
    logic [31:0] exp_pc, prev_instr, prev_pc;
    logic        prev_pred;
    bit          busy, acc_stale;
    int          cnt, lat;
    logic [31:0] acc_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_addi(input int v);
        logic [11:0] im;
        im = v[11:0];
        return {im, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input int o);
        logic [12:0] im;
        im = o[12:0];
        return {im[12], im[10:5], 5'd2, 5'd1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int o);
        logic [20:0] im;
        im = o[20:0];
        return {im[20], im[10:1], im[11], im[19:12], 5'd0, 7'b1101111};
    endfunction

    task automatic model_reset();
        q.delete();
        exp_pc = 32'h0; prev_instr = NOP; prev_pc = 32'h0; prev_pred = 1'b0;
        busy = 0; acc_stale = 0; cnt = 0;
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
    endtask

    // Asserted off the clock edge so the asynchronous path is what clears the outputs.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_instr", o_instr, NOP);
        chk("rst_pc", o_pc, 32'h0);
        chk1("rst_pred", o_prediction, 1'b0);
        chk1("rst_req", o_imem_req, 1'b0);
        i_stall = 0; i_flush = 0; i_branch_pc = 0; i_imem_ack = 0; i_imem_data = 0;
        i_bp_upd_valid = 0; i_bp_upd_pc = 0; i_bp_upd_taken = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs and the memory at a negedge, advance to the next
    // negedge, then check what the edge produced against the scoreboard.
    task automatic cycle(input bit st, input bit fl, input logic [31:0] bpc,
                         input bit uv, input logic [31:0] upc, input bit ut);
        bit   ack, live;
        int   l, k;
        logic p;
        ent_t e;
        ack = 0;
        i_stall = st; i_flush = fl; i_branch_pc = bpc;
        i_bp_upd_valid = uv; i_bp_upd_pc = upc; i_bp_upd_taken = ut;
        if (busy) begin
            if (o_imem_req) chk("addr_hold", o_imem_addr, acc_addr);
            cnt--;
            if (cnt == 0) begin ack = 1; busy = 0; end
        end else if (o_imem_req) begin
            chk("req_addr", o_imem_addr, exp_pc);
            acc_addr = o_imem_addr; acc_stale = 0;
            l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            if (l == 0) ack = 1;
            else begin busy = 1; cnt = l; end
        end
        live = ack && !acc_stale && !fl;
        if (fl) acc_stale = 1;
        i_imem_ack  = ack;
        i_imem_data = ack ? prog[acc_addr[9:2]] : $urandom();
        if (live) begin
            k = kind[acc_addr[9:2]];
            p = (k == 2) || (k == 1 && bht_m[acc_addr[7:2]] >= 2);
            q.push_back('{prog[acc_addr[9:2]], acc_addr, p});
            exp_pc = p ? acc_addr + 32'(off[acc_addr[9:2]]) : acc_addr + 32'd4;
        end
        if (fl) begin q.delete(); exp_pc = bpc; end
        if (uv) begin
            if (ut && bht_m[upc[7:2]] < 3) bht_m[upc[7:2]]++;
            if (!ut && bht_m[upc[7:2]] > 0) bht_m[upc[7:2]]--;
        end
        @(negedge clk);
        if (fl) begin
            chk("flush_instr", o_instr, NOP);
            chk("flush_pc", o_pc, 32'h0);
            chk1("flush_pred", o_prediction, 1'b0);
        end else if (st) begin
            chk("stall_instr", o_instr, prev_instr);
            chk("stall_pc", o_pc, prev_pc);
            chk1("stall_pred", o_prediction, prev_pred);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_instr", o_instr, e.instr);
            chk("out_pc", o_pc, e.pc);
            chk1("out_pred", o_prediction, e.pred);
        end else begin
            chk("bubble_instr", o_instr, NOP);
            chk("bubble_pc", o_pc, prev_pc);
            chk1("bubble_pred", o_prediction, 1'b0);
        end
        if (q.size() > 0) chk1("req_when_buffered", o_imem_req, 1'b0);
        prev_instr = o_instr; prev_pc = o_pc; prev_pred = o_prediction;
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic sync_to_accept();
        int w;
        w = 0;
        while (!(!busy && o_imem_req) && w < 20) begin idle_cycle(); w++; end
        chk1("sync_accept", w < 20, 1'b1);
    endtask

    initial begin
        vec_t        vt [7];
        logic [31:0] fa, fi, fp;
        bit          found;
        int          r;

        vt[0] = '{32'h10, 32'hFE000EE3, 1,  -4, 1, 32'h0000_0014, 1'b0};
        vt[1] = '{32'h10, 32'hFE000EE3, 1,  -4, 2, 32'h0000_000C, 1'b1};
        vt[2] = '{32'h20, 32'h1000006F, 2, 256, 0, 32'h0000_0120, 1'b1};
        vt[3] = '{32'h30, 32'h000080E7, 0,   0, 0, 32'h0000_0034, 1'b0};
        vt[4] = '{32'h40, 32'hFE000EE3, 1,  -4, 3, 32'h0000_003C, 1'b1};
        vt[5] = '{32'h04, 32'hFF9FF06F, 2,  -8, 0, 32'hFFFF_FFFC, 1'b1};
        vt[6] = '{32'h00, 32'hFE000EE3, 1,  -4, 2, 32'hFFFF_FFFC, 1'b1};

        for (int i = 0; i < 256; i++) begin prog[i] = enc_addi(i); kind[i] = 0; off[i] = 0; end
        rst_n = 1'b1; i_stall = 0; i_flush = 0; i_branch_pc = 0; i_imem_ack = 0;
        i_imem_data = 0; i_bp_upd_valid = 0; i_bp_upd_pc = 0; i_bp_upd_taken = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Straight-line fetch with a zero-latency memory.
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            idle_cycle();
            chk("seq_addr", o_imem_addr, 32'(4 * (k - 1)));
            if (k >= 2) chk("seq_pc", o_pc, 32'(4 * (k - 2)));
            chk1("seq_pred", o_prediction, 1'b0);
        end

        // Prediction vectors: preset the counter, redirect onto the word, check the next fetch.
        lat = 1;
        for (int i = 0; i < 7; i++) begin
            prog[vt[i].pc[9:2]] = vt[i].instr;
            kind[vt[i].pc[9:2]] = vt[i].kind;
            off[vt[i].pc[9:2]]  = vt[i].off;
            repeat (3) cycle(0, 0, 32'h0, 1, vt[i].pc, 0);
            for (int j = 0; j < vt[i].ntaken; j++) cycle(0, 0, 32'h0, 1, vt[i].pc, 1);
            cycle(0, 1, vt[i].pc, 0, 32'h0, 0);
            found = 0;
            for (int j = 0; j < 12 && !found; j++) begin
                idle_cycle();
                if (o_pc == vt[i].pc && o_instr == vt[i].instr) found = 1;
            end
            chk1("vec_delivered", found, 1'b1);
            chk1("vec_pred", o_prediction, vt[i].exp_pred);
            chk("vec_next_addr", o_imem_addr, vt[i].exp_next);
            chk1("vec_next_req", o_imem_req, 1'b1);
        end

        // Ack lands inside a 3-cycle stall and must come out right after release.
        lat = 2;
        sync_to_accept();
        fa = o_imem_addr; fi = o_instr; fp = o_pc;
        repeat (3) cycle(1, 0, 32'h0, 0, 32'h0, 0);
        chk1("stall_req_off", o_imem_req, 1'b0);
        chk("stall_frozen_instr", o_instr, fi);
        chk("stall_frozen_pc", o_pc, fp);
        idle_cycle();
        chk("skid_pc", o_pc, fa);
        chk("skid_instr", o_instr, prog[fa[9:2]]);
        idle_cycle();
        chk1("stall_req_resume", o_imem_req, 1'b1);

        // Flush with a request in flight; its response shows up two cycles later.
        lat = 3;
        sync_to_accept();
        idle_cycle();
        cycle(0, 1, 32'h200, 0, 32'h0, 0);
        chk1("drain_req0", o_imem_req, 1'b0);
        idle_cycle();
        chk1("drain_req1", o_imem_req, 1'b0);
        idle_cycle();
        chk1("drain_req_back", o_imem_req, 1'b1);
        chk("drain_addr", o_imem_addr, 32'h200);
        chk("drain_instr", o_instr, NOP);

        // Flush beats stall.
        lat = 1;
        cycle(1, 1, 32'h300, 0, 32'h0, 0);
        chk("fs_instr", o_instr, NOP);
        chk("fs_pc", o_pc, 32'h0);
        found = 0;
        for (int j = 0; j < 6 && !found; j++) begin
            idle_cycle();
            if (o_imem_req && o_imem_addr == 32'h300) found = 1;
        end
        chk1("fs_redirect", found, 1'b1);

        // Random program, stalls, flushes, BHT updates and memory latency.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom_range(0, 99));
            kind[i] = 0; off[i] = 0; prog[i] = enc_addi(i);
            if (r >= 60 && r < 80) begin
                kind[i] = 1; off[i] = (int'($urandom_range(0, 32)) - 16) * 4; prog[i] = enc_b(off[i]);
            end else if (r >= 80 && r < 92) begin
                kind[i] = 2; off[i] = (int'($urandom_range(0, 64)) - 32) * 4; prog[i] = enc_j(off[i]);
            end else if (r >= 92) begin
                prog[i] = 32'h000080E7;
            end
        end
        lat = -1;
        for (int c = 0; c < 2500; c++) begin
            cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 4,
                  {22'h0, 8'($urandom_range(0, 255)), 2'b00},
                  $urandom_range(0, 99) < 20, {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                  $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
